// File: rtl/multicore_shared_ram.sv
module multicore_shared_ram #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter              INIT_FILE    = "multicore_shared_ram.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic [ADDR_WIDTH-1:0]   s0_address,
  input  logic [DATA_WIDTH/8-1:0] s0_byteenable,
  input  logic                    s0_read,
  input  logic                    s0_write,
  input  logic [DATA_WIDTH-1:0]   s0_writedata,
  output logic                    s0_waitrequest,
  output logic [DATA_WIDTH-1:0]   s0_readdata,
  output logic                    s0_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid
);
  localparam int unsigned         NBYTES  = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic {RR_S0 = 1'b0, RR_S1 = 1'b1} rr_t;

  rr_t                   rr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  en, req0, req1, grant0, grant1;
  logic                  acc, acc_wr, acc_rd, acc_port, addr_ok;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [NBYTES-1:0]     acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata, rd_word;

  logic                  pl_v, pl_p;
  logic [DATA_WIDTH-1:0] pl_d;
  logic                  out_v, out_p;

  always_comb begin
    en        = clken & ~reset_req;
    req0      = s0_read | s0_write;
    req1      = s1_read | s1_write;
    grant0    = en & req0 & (~req1 | (rr == RR_S0));
    grant1    = en & req1 & (~req0 | (rr == RR_S1));
    acc       = grant0 | grant1;
    acc_port  = grant1;
    acc_addr  = grant1 ? s1_address    : s0_address;
    acc_be    = grant1 ? s1_byteenable : s0_byteenable;
    acc_wdata = grant1 ? s1_writedata  : s0_writedata;
    acc_wr    = acc & (grant1 ? s1_write : s0_write);
    acc_rd    = acc & ~acc_wr;
    addr_ok   = {1'b0, acc_addr} < DEPTH_L;
    rd_word   = addr_ok ? mem[acc_addr] : '0;
  end

  assign s0_waitrequest   = req0 & ~grant0;
  assign s1_waitrequest   = req1 & ~grant1;
  assign s0_readdatavalid = en & out_v & ~out_p;
  assign s1_readdatavalid = en & out_v & out_p;

  always_ff @(posedge clk) begin
    if (acc_wr && addr_ok) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (acc_be[b]) mem[acc_addr][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr <= RR_S0;
    end else if (en && req0 && req1) begin
      rr <= (rr == RR_S0) ? RR_S1 : RR_S0;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  mid_v, mid_p;
      logic [DATA_WIDTH-1:0] mid_d;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          mid_v <= 1'b0;
          mid_p <= 1'b0;
          mid_d <= '0;
        end else if (en) begin
          mid_v <= acc_rd;
          mid_p <= acc_port;
          mid_d <= rd_word;
        end
      end
      assign pl_v = mid_v;
      assign pl_p = mid_p;
      assign pl_d = mid_d;
    end else begin : g_lat1
      assign pl_v = acc_rd;
      assign pl_p = acc_port;
      assign pl_d = rd_word;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_v       <= 1'b0;
      out_p       <= 1'b0;
      s0_readdata <= '0;
      s1_readdata <= '0;
    end else if (en) begin
      out_v <= pl_v;
      out_p <= pl_p;
      if (pl_v && !pl_p) s0_readdata <= pl_d;
      if (pl_v && pl_p)  s1_readdata <= pl_d;
    end
  end
endmodule

// File: tb/tb_multicore_shared_ram.sv
// Randomised and directed checks of two configurations (latency 1 / depth 1024,
// latency 2 / depth 768) against a queue-based behavioural model.
module tb_multicore_shared_ram;
    localparam int AW = 10;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst, clken, reset_req;

    logic [1:0]                c_rd, c_wr;
    logic [1:0][AW-1:0]        c_addr;
    logic [1:0][DW/8-1:0]      c_be;
    logic [1:0][DW-1:0]        c_wd;
    logic [1:0][1:0]           wq, rv;
    logic [1:0][1:0][DW-1:0]   rd;

    always #5 clk = ~clk;

    multicore_shared_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024),
                           .READ_LATENCY(1), .INIT_FILE("")) dut_a (
        .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req),
        .s0_address(c_addr[0]), .s0_byteenable(c_be[0]), .s0_read(c_rd[0]),
        .s0_write(c_wr[0]), .s0_writedata(c_wd[0]), .s0_waitrequest(wq[0][0]),
        .s0_readdata(rd[0][0]), .s0_readdatavalid(rv[0][0]),
        .s1_address(c_addr[1]), .s1_byteenable(c_be[1]), .s1_read(c_rd[1]),
        .s1_write(c_wr[1]), .s1_writedata(c_wd[1]), .s1_waitrequest(wq[0][1]),
        .s1_readdata(rd[0][1]), .s1_readdatavalid(rv[0][1]));

    multicore_shared_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(768),
                           .READ_LATENCY(2), .INIT_FILE("")) dut_b (
        .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req),
        .s0_address(c_addr[0]), .s0_byteenable(c_be[0]), .s0_read(c_rd[0]),
        .s0_write(c_wr[0]), .s0_writedata(c_wd[0]), .s0_waitrequest(wq[1][0]),
        .s0_readdata(rd[1][0]), .s0_readdatavalid(rv[1][0]),
        .s1_address(c_addr[1]), .s1_byteenable(c_be[1]), .s1_read(c_rd[1]),
        .s1_write(c_wr[1]), .s1_writedata(c_wd[1]), .s1_waitrequest(wq[1][1]),
        .s1_readdata(rd[1][1]), .s1_readdatavalid(rv[1][1]));

    // Reference model: one queue of outstanding reads, each counting down the
    // enabled cycles left before it must appear on its port.
    typedef struct {
        int          k;
        int          p;
        logic [31:0] d;
        int          cnt;
    } rd_t;

    rd_t         pq[$];
    logic [31:0] mm   [2][1024];
    logic [31:0] last [2][2];
    int          lat  [2] = '{1, 2};
    int          dep  [2] = '{1024, 768};
    int          rr_m [2];
    bit   [1:0]  held;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit c_req(input int p);
        return c_rd[p] | c_wr[p];
    endfunction

    function automatic int grant_of(input int k);
        if (!(clken && !reset_req)) return -1;
        if (c_req(0) && c_req(1)) return rr_m[k];
        if (c_req(0)) return 0;
        if (c_req(1)) return 1;
        return -1;
    endfunction

    function automatic int due_idx(input int k, input int p);
        foreach (pq[i]) if (pq[i].k == k && pq[i].p == p && pq[i].cnt == 0) return i;
        return -1;
    endfunction

    task automatic check_cycle();
        bit en;
        int g, i;
        en = clken && !reset_req;
        for (int k = 0; k < 2; k++) begin
            g = grant_of(k);
            for (int p = 0; p < 2; p++) begin
                i = due_idx(k, p);
                check($sformatf("wait_d%0d_s%0d", k, p), wq[k][p], c_req(p) && g != p);
                check($sformatf("rdv_d%0d_s%0d", k, p), rv[k][p], en && i >= 0);
                if (i >= 0 && en) check($sformatf("rdata_d%0d_s%0d", k, p), rd[k][p], pq[i].d);
                else if (i < 0) check($sformatf("rhold_d%0d_s%0d", k, p), rd[k][p], last[k][p]);
            end
        end
    endtask

    task automatic model_edge();
        rd_t e;
        rd_t nq[$];
        int  g[2];
        int  p, a;
        if (!(clken && !reset_req)) return;
        for (int k = 0; k < 2; k++) g[k] = grant_of(k);
        foreach (pq[i]) begin
            e = pq[i];
            if (e.cnt == 0) last[e.k][e.p] = e.d;
            else begin
                e.cnt--;
                nq.push_back(e);
            end
        end
        pq = nq;
        for (int k = 0; k < 2; k++) begin
            if (g[k] >= 0) begin
                p = g[k];
                a = int'(c_addr[p]);
                if (c_wr[p]) begin
                    if (a < dep[k])
                        for (int b = 0; b < 4; b++)
                            if (c_be[p][b]) mm[k][a][8*b +: 8] = c_wd[p][8*b +: 8];
                end else begin
                    e.k = k;
                    e.p = p;
                    e.d = (a < dep[k]) ? mm[k][a] : 32'h0;
                    e.cnt = lat[k] - 1;
                    pq.push_back(e);
                end
            end
        end
        if (c_req(0) && c_req(1)) for (int k = 0; k < 2; k++) rr_m[k] = 1 - rr_m[k];
    endtask

    task automatic cycle();
        #2;
        check_cycle();
        for (int p = 0; p < 2; p++) held[p] = c_req(p) && grant_of(0) != p;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        c_rd = '0; c_wr = '0; c_addr = '0; c_be = '0; c_wd = '0;
    endtask

    task automatic cmd(input int p, input bit r, input bit w, input int a,
                       input logic [3:0] be, input logic [31:0] d);
        c_rd[p] = r; c_wr[p] = w; c_addr[p] = AW'(a); c_be[p] = be; c_wd[p] = d;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                check($sformatf("rst_rdv_d%0d_s%0d", k, p), rv[k][p], 1'b0);
                check($sformatf("rst_rdata_d%0d_s%0d", k, p), rd[k][p], 32'h0);
                last[k][p] = '0;
            end
        pq.delete();
        rr_m[0] = 0;
        rr_m[1] = 0;
        held = '0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          n0, n1;
        int          pulses[$];
        int unsigned op;

        rst = 1'b0; clken = 1'b1; reset_req = 1'b0; held = '0;
        idle();
        @(negedge clk);
        do_reset();

        // Preload every word (word 5 carries the reference image value).
        for (int a = 0; a < 1024; a++) begin
            cmd(0, 1'b0, 1'b1, a, 4'hF, (a == 5) ? 32'hDEADBEEF : 32'($urandom));
            cycle();
        end
        idle();

        // Latency-1 read of image word 5.
        cmd(0, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        #1 check("img_wait", wq[0][0], 1'b0);
        cycle();
        idle();
        #1;
        check("img_rdv", rv[0][0], 1'b1);
        check("img_data", rd[0][0], 32'hDEADBEEF);
        check("img_s1_idle", rv[0][1], 1'b0);
        cycle();
        cycle();

        // Byte-lane merge, read issued right after the write.
        cmd(0, 1'b0, 1'b1, 40, 4'hF, 32'hAABBCCDD);
        cycle();
        cmd(0, 1'b1, 1'b1, 40, 4'b0101, 32'h11223344);
        cycle();
        cmd(0, 1'b1, 1'b0, 40, 4'h0, 32'h0);
        cycle();
        idle();
        #1;
        check("be_rdv", rv[0][0], 1'b1);
        check("be_data", rd[0][0], 32'hAA22CC44);
        cycle();
        cycle();

        // Continuous reads on both ports straight after reset.
        do_reset();
        c_rd = 2'b11; c_addr[0] = AW'(10); c_addr[1] = AW'(20);
        n0 = 0; n1 = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) idle();
            #1;
            if (i < 4) begin
                check("rr_wait_s0", wq[0][0], (i % 2) == 1);
                check("rr_wait_s1", wq[0][1], (i % 2) == 0);
            end
            n0 += int'(rv[0][0]);
            n1 += int'(rv[0][1]);
            cycle();
        end
        check("rr_pulses_s0", n0, 2);
        check("rr_pulses_s1", n1, 2);
        cycle();

        // Latency-2 stream on s1 with one disabled cycle in the middle.
        for (int i = 0; i < 8; i++) begin
            idle();
            clken = (i != 2);
            if (i <= 1) cmd(1, 1'b1, 1'b0, 100 + i, 4'h0, 32'h0);
            else if (i <= 3) cmd(1, 1'b1, 1'b0, 102, 4'h0, 32'h0);
            #1;
            if (rv[1][1]) begin
                check("lat2_data", rd[1][1], mm[1][100 + pulses.size()]);
                pulses.push_back(i);
            end
            cycle();
        end
        clken = 1'b1;
        check("lat2_count", pulses.size(), 3);
        for (int j = 0; j < 3; j++)
            check($sformatf("lat2_cycle%0d", j), (j < pulses.size()) ? pulses[j] : -1, 3 + j);

        // Reset while a read is in flight; memory must survive.
        cmd(0, 1'b1, 1'b0, 40, 4'h0, 32'h0);
        cycle();
        do_reset();
        for (int i = 0; i < 3; i++) cycle();
        cmd(0, 1'b1, 1'b0, 40, 4'h0, 32'h0);
        cycle();
        idle();
        #1;
        check("post_rst_rdv", rv[0][0], 1'b1);
        check("post_rst_data", rd[0][0], 32'hAA22CC44);
        cycle();
        cycle();

        // Out-of-range access on the 768-word instance.
        cmd(0, 1'b0, 1'b1, 800, 4'hF, 32'h55AA55AA);
        cycle();
        cmd(0, 1'b1, 1'b0, 800, 4'h0, 32'h0);
        cycle();
        idle();
        cycle();
        #1;
        check("oor_rdv", rv[1][0], 1'b1);
        check("oor_data", rd[1][0], 32'h0);
        cycle();
        cmd(0, 1'b1, 1'b0, 32, 4'h0, 32'h0);
        cycle();
        idle();
        cycle();
        #1;
        check("alias_rdv", rv[1][0], 1'b1);
        check("alias_data", rd[1][0], mm[1][32]);
        cycle();

        // Randomised traffic with clock-enable, hold-off and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            for (int p = 0; p < 2; p++) begin
                if (!held[p]) begin
                    op = $urandom_range(0, 3);
                    c_rd[p] = op[0];
                    c_wr[p] = op[1];
                    c_addr[p] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15))
                                                            : AW'($urandom_range(0, 1023));
                    c_be[p] = 4'($urandom);
                    c_wd[p] = 32'($urandom);
                end
            end
            clken = ($urandom_range(0, 9) != 0);
            reset_req = ($urandom_range(0, 19) == 0);
            cycle();
        end
        idle();
        clken = 1'b1;
        reset_req = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/multicore_shared_ram.md
MULTICORE_SHARED_RAM -- requirements
Module: multicore_shared_ram

Interface
REQ-001 Parameter DATA_WIDTH, default 32, word width in bits; SHALL be a multiple of 8 in the range 8..128.
REQ-002 Parameter ADDR_WIDTH, default 10, word-address width.
REQ-003 Parameter DEPTH, default 1024, number of words; SHALL satisfy DEPTH <= 2**ADDR_WIDTH.
REQ-004 Parameter READ_LATENCY, default 1, cycles from command acceptance to readdatavalid; legal values are 1 and 2.
REQ-005 Parameter INIT_FILE, default "multicore_shared_ram.hex", memory initialisation image.
REQ-006 Ports:
- clk  in  1  single clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clken  in  1  global clock enable.
- reset_req  in  1  reset-request hold-off; while high, behaves as clken=0.
- sN_address  in  ADDR_WIDTH  word address, N in {0,1}.
- sN_byteenable  in  DATA_WIDTH/8  write byte lanes.
- sN_read / sN_write  in  1  command strobes.
- sN_writedata  in  DATA_WIDTH  write data.
- sN_waitrequest  out  1  command not accepted this cycle.
- sN_readdata  out  DATA_WIDTH  read data.
- sN_readdatavalid  out  1  one-cycle read-return strobe.

Function
REQ-007 Single memory array of DEPTH x DATA_WIDTH; at most one access (read or write) SHALL be performed per enabled cycle.
REQ-008 Port N requests when sN_read|sN_write; enabled cycle = clken & ~reset_req.
REQ-009 Grant: exactly one requester -> that port; both -> port selected by round-robin pointer rr; no grant when the cycle is not enabled.
REQ-010 rr SHALL toggle to the other port only after a cycle in which both ports requested and a grant was issued; otherwise rr holds.
REQ-011 sN_waitrequest = request_N & ~grant_N (combinational); when not requesting, waitrequest SHALL be 0.
REQ-012 A port held off by waitrequest SHALL keep its command stable; its command is accepted in the first cycle it is granted.
REQ-013 Accepted write: memory bytes whose byteenable bit is 1 SHALL be updated at that clock edge; other bytes unchanged; no readdatavalid.
REQ-014 sN_read and sN_write asserted together: treated as a write only.
REQ-015 Accepted read: sN_readdatavalid SHALL pulse exactly READ_LATENCY enabled cycles later, with sN_readdata valid in that same cycle.
REQ-016 Back-to-back reads (one per cycle) SHALL be fully pipelined; each returns in order on its issuing port.
REQ-017 A read accepted the cycle after a write to the same address SHALL return the new data; a read and write in the same cycle is impossible (REQ-007).
REQ-018 Disabled cycle: read pipeline stalls, valid bits and readdata hold their values, and readdatavalid outputs are forced to 0; the pipeline resumes when enabled.
REQ-019 Address >= DEPTH: a write is accepted and discarded; a read is accepted and returns all-zero data with a normal readdatavalid.
REQ-020 sN_readdata holds its last returned value between readdatavalid pulses.

Reset
REQ-021 On reset assertion, immediately: all read-pipeline valid bits cleared, sN_readdatavalid=0, sN_readdata=0, rr=port 0.
REQ-022 Memory contents SHALL NOT be cleared by reset; INIT_FILE contents apply at configuration only.
REQ-023 Reads in flight at reset assertion SHALL be dropped with no readdatavalid after reset release.
REQ-024 The first cycle after reset deassertion SHALL arbitrate normally.

Verification
REQ-025 Image word 5 = 0xDEADBEEF, READ_LATENCY=1; s0 reads address 5 -> s0_waitrequest=0, and the next cycle s0_readdatavalid=1 and s0_readdata=0xDEADBEEF; s1 idle with s1_readdatavalid=0.
REQ-026 s0 writes 0x11223344 with byteenable 4'b0101 to a word holding 0xAABBCCDD, then reads it -> 0xAA22CC44.
REQ-027 Both ports read continuously for 4 cycles after reset -> grants s0,s1,s0,s1; the held-off port sees waitrequest=1; each port receives 2 readdatavalid pulses.
REQ-028 READ_LATENCY=2; s1 issues 3 back-to-back reads while clken drops for 1 cycle mid-stream -> 3 in-order readdatavalid pulses, with the gap cycle's pulse delayed by exactly 1 cycle.
REQ-029 Reset asserted 1 cycle after a read is accepted -> no readdatavalid afterwards; readdata=0; subsequent read of the same address returns the pre-reset memory value.
REQ-030 DEPTH=768: write to address 800 followed by a read of address 800 -> readdata=0; address 800 mod 768 = 32 is unchanged.
